// File: rtl/jpeg_bitpacker_pkg.sv
// jpeg_bitpacker_pkg: byte values shared by the encoder and decoder marker logic
package jpeg_bitpacker_pkg;
    localparam logic [7:0] JPEG_MARKER_PREFIX = 8'hFF;
    localparam logic [7:0] JPEG_STUFF_BYTE    = 8'h00;
endpackage

// File: rtl/jpeg_bitpacker.sv
// jpeg_bitpacker: packs 0..32-bit codes MSB-first into bytes with 0xFF/0x00 stuffing and end-of-image padding
module jpeg_bitpacker
    import jpeg_bitpacker_pkg::*;
#(
    parameter bit   STUFF_EN = 1'b1,
    parameter logic PAD_BIT  = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        img_start_i,
    input  logic        inport_valid_i,
    input  logic [31:0] inport_data_i,
    input  logic [5:0]  inport_len_i,
    input  logic        inport_last_i,
    output logic        inport_accept_o,
    output logic        outport_valid_o,
    output logic [7:0]  outport_data_o,
    output logic        outport_last_o,
    input  logic        outport_accept_i,
    output logic        done_o
);
    typedef enum logic [1:0] {ACTIVE, DRAIN, DONE} state_e;

    function automatic logic [31:0] len_mask(input logic [5:0] len);
        return (len >= 6'd32) ? 32'hFFFF_FFFF : ((32'h1 << len) - 32'h1);
    endfunction

    logic [63:0] acc_q, acc_d, code;
    logic [6:0]  count_q, count_d, popped, after_pop;
    logic        stuff_q, stuff_d, push, pop, data_byte, clr;
    logic [5:0]  len;
    logic [7:0]  pad_byte;
    state_e      state_q, state_d;

    assign len             = (inport_len_i > 6'd32) ? 6'd32 : inport_len_i;
    assign inport_accept_o = (state_q == ACTIVE) && (count_q <= 7'd32);
    assign push            = inport_valid_i & inport_accept_o;
    assign pad_byte        = (acc_q[63:56] & ~(8'hFF >> count_q)) | (PAD_BIT ? (8'hFF >> count_q) : 8'h00);
    assign data_byte       = !stuff_q && (count_q >= 7'd8 || (state_q == DRAIN && count_q != 7'd0));
    assign outport_valid_o = stuff_q | data_byte;
    assign outport_data_o  = stuff_q ? JPEG_STUFF_BYTE : (count_q >= 7'd8) ? acc_q[63:56] : data_byte ? pad_byte : 8'h00;
    assign outport_last_o  = (state_q == DRAIN) && (stuff_q ? (count_q == 7'd0) :
                             (data_byte && count_q <= 7'd8 && !(STUFF_EN && outport_data_o == JPEG_MARKER_PREFIX)));
    assign pop             = outport_valid_o & outport_accept_i;
    assign popped          = (pop && data_byte) ? ((count_q >= 7'd8) ? 7'd8 : count_q) : 7'd0;
    assign after_pop       = count_q - popped;
    assign code            = {32'h0, inport_data_i & len_mask(len)} << (7'd64 - {1'b0, len});
    assign done_o          = (state_q == DONE);
    assign clr             = img_start_i || (state_q == DONE);

    // next accumulator: shift out the popped bits, then merge the new code just below what remains
    always_comb begin
        acc_d   = clr ? 64'h0 : (acc_q << popped) | (push ? (code >> after_pop) : 64'h0);
        count_d = clr ? 7'd0 : after_pop + (push ? {1'b0, len} : 7'd0);
        stuff_d = clr ? 1'b0 : pop ? (data_byte && STUFF_EN && outport_data_o == JPEG_MARKER_PREFIX) : stuff_q;
        state_d = clr ? ACTIVE :
                  (state_q == DRAIN || (push && inport_last_i)) ? ((count_d == 7'd0 && !stuff_d) ? DONE : DRAIN) :
                  ACTIVE;
    end

    // state registers with asynchronous reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q   <= 64'h0;
            count_q <= 7'd0;
            stuff_q <= 1'b0;
            state_q <= ACTIVE;
        end else begin
            acc_q   <= acc_d;
            count_q <= count_d;
            stuff_q <= stuff_d;
            state_q <= state_d;
        end
    end
endmodule

// File: tb/tb_jpeg_bitpacker.sv
// tb_jpeg_bitpacker: scoreboard bench for jpeg_bitpacker against a bit-queue reference model
module tb_jpeg_bitpacker;
    logic        clk = 1'b0, rst_i = 1'b1, img_start_i = 1'b0;
    logic        inport_valid_i = 1'b0, inport_last_i = 1'b0, outport_accept_i = 1'b0;
    logic [31:0] inport_data_i = 32'h0;
    logic [5:0]  inport_len_i = 6'd0;
    logic        inport_accept_o, outport_valid_o, outport_last_o, done_o;
    logic [7:0]  outport_data_o;

    logic        ns_valid = 1'b0, ns_accept_o, ns_ovalid, ns_olast, ns_done;
    logic [7:0]  ns_odata;

    typedef struct { logic [7:0] d; logic l; } exp_t;
    exp_t exp_q[$];
    bit   bitq[$];
    int   errors = 0, checks = 0, exp_done = 0, done_cnt = 0;
    bit   stall_force = 0, prev_stall = 0, done_next = 0, after_done = 0;
    logic [7:0] prev_d;
    logic prev_l;

    always #5 clk = ~clk;

    jpeg_bitpacker u_dut (
        .clk_i(clk), .rst_i(rst_i), .img_start_i(img_start_i),
        .inport_valid_i(inport_valid_i), .inport_data_i(inport_data_i), .inport_len_i(inport_len_i),
        .inport_last_i(inport_last_i), .inport_accept_o(inport_accept_o),
        .outport_valid_o(outport_valid_o), .outport_data_o(outport_data_o), .outport_last_o(outport_last_o),
        .outport_accept_i(outport_accept_i), .done_o(done_o)
    );

    jpeg_bitpacker #(.STUFF_EN(1'b0)) u_ns (
        .clk_i(clk), .rst_i(rst_i), .img_start_i(1'b0),
        .inport_valid_i(ns_valid), .inport_data_i(32'hFF), .inport_len_i(6'd8),
        .inport_last_i(1'b0), .inport_accept_o(ns_accept_o),
        .outport_valid_o(ns_ovalid), .outport_data_o(ns_odata), .outport_last_o(ns_olast),
        .outport_accept_i(1'b1), .done_o(ns_done)
    );

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // reference: the image is one bit string; bytes are its 8-bit slices, each 0xFF followed by 0x00
    task automatic model_push(input logic [31:0] d, input logic [5:0] len, input logic lst);
        int l;
        logic [7:0] b;
        l = (len > 6'd32) ? 32 : int'(len);
        for (int i = l - 1; i >= 0; i--) bitq.push_back(d[i]);
        if (lst) while (bitq.size() % 8 != 0) bitq.push_back(1'b1);
        while (bitq.size() >= 8) begin
            b = 8'h00;
            for (int i = 0; i < 8; i++) b = {b[6:0], bitq.pop_front()};
            exp_q.push_back('{d: b, l: 1'b0});
            if (b == 8'hFF) exp_q.push_back('{d: 8'h00, l: 1'b0});
        end
        if (lst) begin
            if (l > 0) exp_q[exp_q.size() - 1].l = 1'b1;
            exp_done++;
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [5:0] len, input logic lst, input bit track);
        bit a;
        int n;
        inport_valid_i = 1'b1; inport_data_i = d; inport_len_i = len; inport_last_i = lst;
        n = 0;
        forever begin
            a = inport_accept_o;
            @(posedge clk);
            if (a) begin
                if (track) model_push(d, len, lst);
                break;
            end
            @(negedge clk);
            if (++n > 3000) begin
                chk(0, "push_timeout", 32'(n), 32'd3000);
                break;
            end
        end
        @(negedge clk);
        inport_valid_i = 1'b0; inport_last_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && inport_accept_o) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(n < 3000, "idle_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    // monitor: drives downstream accept and compares every transferred byte against the scoreboard
    always @(negedge clk) begin
        if (!rst_i) begin
            if (done_o) done_cnt++;
            if (after_done) chk(inport_accept_o == 1'b1, "accept_after_done", 32'(inport_accept_o), 32'd1);
            after_done = 0;
            if (done_next) begin
                chk(done_o == 1'b1, "done_pulse", 32'(done_o), 32'd1);
                after_done = 1;
            end
            done_next = 0;
            if (prev_stall && !stall_force)
                chk(outport_valid_o && outport_data_o == prev_d && outport_last_o == prev_l, "stall_hold",
                    {23'h0, outport_valid_o, outport_data_o}, {23'h1, prev_d});
            outport_accept_i = stall_force ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (outport_valid_o && outport_accept_i) begin
                if (exp_q.size() == 0) chk(0, "unexpected_byte", 32'(outport_data_o), 32'h0);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk(outport_data_o == e.d && outport_last_o == e.l, "byte",
                        {23'h0, outport_last_o, outport_data_o}, {23'h0, e.l, e.d});
                end
                if (outport_last_o) done_next = 1;
            end
            prev_stall = outport_valid_o && !outport_accept_i;
            prev_d = outport_data_o;
            prev_l = outport_last_o;
        end
    end

    initial begin
        int d0, n;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        chk(inport_accept_o == 1'b1, "rst_accept", 32'(inport_accept_o), 32'd1);
        chk(outport_valid_o == 1'b0, "rst_valid", 32'(outport_valid_o), 32'd0);
        chk(outport_data_o == 8'h00, "rst_data", 32'(outport_data_o), 32'd0);
        chk(outport_last_o == 1'b0, "rst_last", 32'(outport_last_o), 32'd0);
        chk(done_o == 1'b0, "rst_done", 32'(done_o), 32'd0);

        ns_valid = 1'b1;
        @(negedge clk);
        ns_valid = 1'b0;
        chk(ns_ovalid && ns_odata == 8'hFF, "nostuff_ff", {23'h0, ns_ovalid, ns_odata}, 32'h1FF);
        @(negedge clk);
        chk(ns_ovalid == 1'b0, "nostuff_no00", 32'(ns_ovalid), 32'd0);

        push(32'hA5, 6'd8, 1'b0, 1);
        chk(inport_accept_o == 1'b1, "accept_after_a5", 32'(inport_accept_o), 32'd1);
        push(32'hFF, 6'd8, 1'b0, 1);
        wait_idle();
        push(32'h5, 6'd3, 1'b1, 1);
        wait_idle();
        push(32'h7F, 6'd7, 1'b1, 1);
        wait_idle();

        stall_force = 1;
        push(32'h1234_5678, 6'd32, 1'b0, 1);
        push(32'h9ABC_DEF0, 6'd32, 1'b0, 1);
        chk(inport_accept_o == 1'b0, "accept_full", 32'(inport_accept_o), 32'd0);
        stall_force = 0;
        wait_idle();

        d0 = done_cnt;
        push(32'h0, 6'd0, 1'b1, 1);
        chk(done_o == 1'b1, "empty_flush_done", 32'(done_o), 32'd1);
        @(negedge clk);
        chk(done_cnt == d0 + 1, "empty_flush_once", 32'(done_cnt), 32'(d0 + 1));
        wait_idle();

        stall_force = 1;
        repeat (2) @(negedge clk);
        push(32'hABCD, 6'd16, 1'b1, 0);
        d0 = done_cnt;
        img_start_i = 1'b1;
        @(negedge clk);
        img_start_i = 1'b0;
        chk(outport_valid_o == 1'b0, "abort_valid", 32'(outport_valid_o), 32'd0);
        chk(inport_accept_o == 1'b1, "abort_accept", 32'(inport_accept_o), 32'd1);
        repeat (4) @(negedge clk);
        chk(done_cnt == d0, "abort_nodone", 32'(done_cnt), 32'(d0));
        stall_force = 0;
        push(32'hFFFF_FF3C, 6'd8, 1'b0, 1);
        wait_idle();

        for (int img = 0; img < 30; img++) begin
            int nc;
            nc = $urandom_range(1, 10);
            for (int k = 0; k < nc; k++) begin
                logic [31:0] d;
                logic [5:0]  l;
                d = $urandom;
                if ($urandom_range(0, 3) == 0) d = 32'hFFFF_FFFF;
                l = 6'($urandom_range(k == nc - 1 ? 1 : 0, 40));
                push(d, l, k == nc - 1, 1);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        wait_idle();
        n = 0;
        while (done_cnt != exp_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk(exp_q.size() == 0, "drain_all", 32'(exp_q.size()), 32'd0);
        chk(done_cnt == exp_done, "done_count", 32'(done_cnt), 32'(exp_done));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
